// File: rtl/combo_lock_pkg.sv
// ============================================================================
//  Module      : combo_lock_pkg
//  Description : Shared state encoding, constants and width helpers for the
//                keypad combination lock controller.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

package combo_lock_pkg;

    typedef enum logic [1:0] {
        ENROLL   = 2'd0,
        ARMED    = 2'd1,
        UNLOCKED = 2'd2,
        LOCKOUT  = 2'd3
    } state_t;

    localparam int unsigned KEY_NONE = 0;

    // Bits needed to hold values 0..n-1, never narrower than one bit.
    function automatic int unsigned width_of(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int unsigned timer_width(input int unsigned a, input int unsigned b);
        return width_of(((a > b) ? a : b) + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/combo_key_event.sv
// ============================================================================
//  Module      : combo_key_event
//  Description : Turns a level keypad code into one press event per keystroke.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module combo_key_event
    import combo_lock_pkg::*;
#(
    parameter int KEY_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [KEY_W-1:0] key_i,
    output logic             press_o,
    output logic [KEY_W-1:0] key_o
);

    logic w_idle;
    logic r_release;

    assign w_idle = (key_i == KEY_W'(KEY_NONE));

    // Armed only after an idle cycle; a key held through reset stays silent.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_release <= 1'b0;
        end else begin
            r_release <= w_idle;
        end
    end

    assign press_o = !w_idle && r_release;
    assign key_o   = key_i;

endmodule

`default_nettype wire

// File: rtl/combo_lock_ctrl.sv
// ============================================================================
//  Module      : combo_lock_ctrl
//  Description : Enrolment / verification FSM with failed-attempt lockout and
//                auto-relock timer for a keypad combination lock.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module combo_lock_ctrl
    import combo_lock_pkg::*;
#(
    parameter int DIGITS      = 4,
    parameter int KEY_W       = 4,
    parameter int MAX_FAILS   = 3,
    parameter int LOCKOUT_CYC = 1000,
    parameter int RELOCK_CYC  = 5000
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [KEY_W-1:0]                    key_i,
    input  logic                                relock_i,
    input  logic                                master_clr_i,
    output logic                                unlock_o,
    output logic                                locked_out_o,
    output logic                                enrolled_o,
    output logic [width_of(DIGITS)-1:0]         digit_idx_o,
    output logic [width_of(MAX_FAILS+1)-1:0]    fail_cnt_o
);

    localparam int IW = width_of(DIGITS);
    localparam int FW = width_of(MAX_FAILS + 1);
    localparam int TW = timer_width(LOCKOUT_CYC, RELOCK_CYC);

    localparam logic [IW-1:0] c_last_idx  = IW'(DIGITS - 1);
    localparam logic [FW-1:0] c_fail_max  = FW'(MAX_FAILS);
    localparam logic [FW-1:0] c_fail_last = FW'(MAX_FAILS - 1);
    localparam logic [TW-1:0] c_relock    = TW'(RELOCK_CYC - 1);
    localparam logic [TW-1:0] c_lockout   = TW'(LOCKOUT_CYC - 1);

    state_t           r_state;
    logic [KEY_W-1:0] r_code [DIGITS];
    logic [IW-1:0]    r_digit_idx;
    logic [FW-1:0]    r_fail_cnt;
    logic [TW-1:0]    r_timer;

    logic             w_press;
    logic [KEY_W-1:0] w_key;
    logic             w_match;

    combo_key_event #(
        .KEY_W   (KEY_W)
    ) u_key_event (
        .clk     (clk),
        .rst_n   (rst_n),
        .key_i   (key_i),
        .press_o (w_press),
        .key_o   (w_key)
    );

    assign w_match = (w_key == r_code[r_digit_idx]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ENROLL;
            for (int i = 0; i < DIGITS; i++) r_code[i] <= '0;
            r_digit_idx <= '0;
            r_fail_cnt  <= '0;
            r_timer     <= '0;
        end else if (master_clr_i) begin
            r_state     <= ENROLL;
            for (int i = 0; i < DIGITS; i++) r_code[i] <= '0;
            r_digit_idx <= '0;
            r_fail_cnt  <= '0;
            r_timer     <= '0;
        end else begin
            case (r_state)
                ENROLL: begin
                    if (w_press) begin
                        r_code[r_digit_idx] <= w_key;
                        if (r_digit_idx == c_last_idx) begin
                            r_state     <= ARMED;
                            r_digit_idx <= '0;
                        end else begin
                            r_digit_idx <= r_digit_idx + 1'b1;
                        end
                    end
                end
                ARMED: begin
                    if (w_press) begin
                        if (w_match) begin
                            if (r_digit_idx == c_last_idx) begin
                                r_state     <= UNLOCKED;
                                r_fail_cnt  <= '0;
                                r_digit_idx <= '0;
                                r_timer     <= c_relock;
                            end else begin
                                r_digit_idx <= r_digit_idx + 1'b1;
                            end
                        end else begin
                            // A wrong key restarts the entry; it is not a first digit.
                            r_digit_idx <= '0;
                            if (r_fail_cnt == c_fail_last) begin
                                r_fail_cnt <= c_fail_max;
                                r_state    <= LOCKOUT;
                                r_timer    <= c_lockout;
                            end else begin
                                r_fail_cnt <= r_fail_cnt + 1'b1;
                            end
                        end
                    end
                end
                UNLOCKED: begin
                    if (relock_i) begin
                        r_state     <= ENROLL;
                        for (int i = 0; i < DIGITS; i++) r_code[i] <= '0;
                        r_digit_idx <= '0;
                    end else if (r_timer == '0) begin
                        r_state <= ARMED;
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end
                LOCKOUT: begin
                    if (r_timer == '0) begin
                        r_state     <= ARMED;
                        r_fail_cnt  <= '0;
                        r_digit_idx <= '0;
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end
                default: r_state <= ENROLL;
            endcase
        end
    end

    assign unlock_o     = (r_state == UNLOCKED);
    assign locked_out_o = (r_state == LOCKOUT);
    assign enrolled_o   = (r_state != ENROLL);
    assign digit_idx_o  = r_digit_idx;
    assign fail_cnt_o   = r_fail_cnt;

endmodule

`default_nettype wire

// File: tb/tb_combo_lock_ctrl.sv
// ============================================================================
//  Module      : tb_combo_lock_ctrl
//  Description : Directed self-checking bench for combo_lock_ctrl.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_combo_lock_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] key = 4'd0;
    logic       relock = 1'b0;
    logic       mclr = 1'b0;
    logic       unlock;
    logic       locked_out;
    logic       enrolled;
    logic [1:0] digit_idx;
    logic [1:0] fail_cnt;

    int vectors = 0;
    int miscompares = 0;
    int n;

    combo_lock_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .key_i        (key),
        .relock_i     (relock),
        .master_clr_i (mclr),
        .unlock_o     (unlock),
        .locked_out_o (locked_out),
        .enrolled_o   (enrolled),
        .digit_idx_o  (digit_idx),
        .fail_cnt_o   (fail_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input logic [3:0] k);
        key = k;
        tick();
    endtask

    task automatic press(input logic [3:0] k);
        apply(k);
        apply(4'd0);
    endtask

    // Called right after the edge that raised unlock; counts total high cycles.
    task automatic count_unlock(output int cnt);
        cnt = 1;
        key = 4'd0;
        for (int i = 0; i < 6000 && unlock; i++) begin
            tick();
            if (unlock) cnt++;
        end
    endtask

    task automatic enter_3141();
        press(4'd3); press(4'd1); press(4'd4);
        apply(4'd1);
    endtask

    initial begin
        // Reset with key 5 held
        key = 4'd5;
        tick();
        chk("rst_unlock", unlock, 0);
        chk("rst_locked", locked_out, 0);
        chk("rst_enrolled", enrolled, 0);
        chk("rst_idx", digit_idx, 0);
        chk("rst_fail", fail_cnt, 0);
        #2 rst_n = 1'b1;
        repeat (3) tick();
        chk("held_key_no_event", digit_idx, 0);

        // Enrol 3,1,4,1
        apply(4'd0);
        press(4'd3);
        chk("enroll_idx1", digit_idx, 1);
        press(4'd1); press(4'd4);
        chk("enroll_idx3", digit_idx, 3);
        press(4'd1);
        chk("enrolled", enrolled, 1);
        chk("enroll_idx_wrap", digit_idx, 0);

        // Verify and time the unlock window
        enter_3141();
        chk("unlock_on_last_edge", unlock, 1);
        count_unlock(n);
        chk("unlock_cycles", n, 5000);
        chk("relock_armed", enrolled, 1);

        // Held key gives a single event
        key = 4'd3;
        repeat (20) tick();
        chk("held_one_event", digit_idx, 1);
        apply(4'd0);
        press(4'd1); press(4'd4);
        apply(4'd1);
        chk("held_then_unlock", unlock, 1);
        count_unlock(n);
        chk("unlock_cycles2", n, 5000);

        // Three wrong entries -> lockout
        press(4'd3); press(4'd9);
        chk("fail1", fail_cnt, 1);
        chk("fail1_idx", digit_idx, 0);
        press(4'd3); press(4'd9);
        chk("fail2", fail_cnt, 2);
        press(4'd3); apply(4'd9);
        chk("lockout_on", locked_out, 1);
        chk("lockout_fail_sat", fail_cnt, 3);
        n = 1;
        for (int i = 0; i < 1200 && locked_out; i++) begin
            key = (i == 10) ? 4'd3 : 4'd0;
            relock = (i == 20);
            tick();
            if (locked_out) n++;
        end
        relock = 1'b0;
        key = 4'd0;
        chk("lockout_cycles", n, 1000);
        chk("post_lockout_fail", fail_cnt, 0);
        chk("post_lockout_idx", digit_idx, 0);
        chk("post_lockout_enrolled", enrolled, 1);
        apply(4'd0);
        enter_3141();
        chk("post_lockout_unlock", unlock, 1);

        // Relock on the same cycle the timer hits zero
        key = 4'd0;
        repeat (4999) tick();
        chk("unlock_before_expiry", unlock, 1);
        relock = 1'b1;
        tick();
        relock = 1'b0;
        chk("relock_prio_unlock", unlock, 0);
        chk("relock_prio_enrolled", enrolled, 0);
        press(4'd7); press(4'd7); press(4'd7); press(4'd7);
        chk("new_code_enrolled", enrolled, 1);
        press(4'd3);
        chk("old_code_fails", fail_cnt, 1);
        press(4'd7); press(4'd7); press(4'd7); apply(4'd7);
        chk("new_code_unlock", unlock, 1);
        chk("new_code_fail_clr", fail_cnt, 0);

        // Master clear from UNLOCKED, mid-verify and mid-lockout
        apply(4'd0);
        mclr = 1'b1; tick(); mclr = 1'b0;
        chk("mclr_unlock", unlock, 0);
        chk("mclr_enrolled", enrolled, 0);
        press(4'd3); press(4'd1); press(4'd4); press(4'd1);
        press(4'd3); press(4'd1);
        chk("mid_verify_idx", digit_idx, 2);
        mclr = 1'b1; apply(4'd4); mclr = 1'b0;
        chk("mclr_verify_enrolled", enrolled, 0);
        chk("mclr_beats_event", digit_idx, 0);
        apply(4'd0);
        press(4'd3); press(4'd1); press(4'd4); press(4'd1);
        press(4'd9); press(4'd9); press(4'd9);
        chk("mclr_pre_lockout", locked_out, 1);
        repeat (5) tick();
        mclr = 1'b1; tick(); mclr = 1'b0;
        chk("mclr_lockout_off", locked_out, 0);
        chk("mclr_lockout_fail", fail_cnt, 0);
        chk("mclr_lockout_enrolled", enrolled, 0);

        // Async reset mid-UNLOCKED
        press(4'd3); press(4'd1); press(4'd4); press(4'd1);
        enter_3141();
        key = 4'd0;
        chk("pre_async_unlock", unlock, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_unlock", unlock, 0);
        chk("async_rst_enrolled", enrolled, 0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("after_rst_idx", digit_idx, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
